// File: rtl/zio_cycle_if.sv
// Z80 I/O bus bundle: raw strobes/address/data from the CPU side and the
// classified cycle strobes and latched fields handed to the port decoders.
interface zio_cycle_if;
  logic        iorq_n;
  logic        m1_n;
  logic        rd_n;
  logic        wr_n;
  logic [15:0] a;
  logic [7:0]  d;
  logic        iorq;
  logic        rd;
  logic [15:0] io_addr;
  logic [7:0]  io_wdata;
  logic        io_rd_begin;
  logic        io_rd_end;
  logic        io_wr_begin;
  logic        io_wr_end;
  logic        int_ack;
  logic        busy;

  modport master (
    output iorq_n, m1_n, rd_n, wr_n, a, d,
    input  iorq, rd, io_addr, io_wdata, io_rd_begin, io_rd_end,
    input  io_wr_begin, io_wr_end, int_ack, busy
  );

  modport slave (
    input  iorq_n, m1_n, rd_n, wr_n, a, d,
    output iorq, rd, io_addr, io_wdata, io_rd_begin, io_rd_end,
    output io_wr_begin, io_wr_end, int_ack, busy
  );
endinterface

// File: rtl/zio_cycle.sv
// Z80 I/O cycle front-end: synchronises and filters bus strobes into fclk,
// classifies read/write/INTA cycles and latches address and write data.
module zio_cycle #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT        = 2
) (
  input logic        fclk,
  input logic        rst_n,
  zio_cycle_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StRd, StWr, StAck, StGap} state_e;

  localparam int unsigned NumStb = 4;
  localparam logic [2:0]  CntMax = 3'(FILT - 1);

  // Strobe index: 0 iorq, 1 m1, 2 rd, 3 wr; all carried active-high internally.
  logic [NumStb-1:0]      raw;
  logic [SYNC_STAGES-1:0] sync_q [NumStb];
  logic [2:0]             cnt_q  [NumStb];
  logic [2:0]             cnt_d  [NumStb];
  logic [NumStb-1:0]      lvl_q, lvl_d;
  logic                   iorq_f, m1_f, rd_f, wr_f;

  state_e      state_q;
  logic        iorq_q, rd_q, busy_q;
  logic        rd_begin_q, rd_end_q, wr_begin_q, wr_end_q, int_ack_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;

  assign raw = ~{bus.wr_n, bus.rd_n, bus.m1_n, bus.iorq_n};

  always_comb begin
    for (int i = 0; i < NumStb; i++) begin
      lvl_d[i] = lvl_q[i];
      cnt_d[i] = '0;
      if (sync_q[i][SYNC_STAGES-1] != lvl_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          lvl_d[i] = ~lvl_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 3'd1;
        end
      end
    end
  end

  // Level outputs take the filter next-state so raw-to-output latency is SYNC_STAGES+FILT.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumStb; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      lvl_q  <= '0;
      iorq_q <= 1'b0;
      rd_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NumStb; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        cnt_q[i]  <= cnt_d[i];
      end
      lvl_q  <= lvl_d;
      iorq_q <= lvl_d[0] & ~lvl_d[1];
      rd_q   <= lvl_d[2];
    end
  end

  assign iorq_f = lvl_q[0];
  assign m1_f   = lvl_q[1];
  assign rd_f   = lvl_q[2];
  assign wr_f   = lvl_q[3];

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      rd_begin_q <= 1'b0;
      rd_end_q   <= 1'b0;
      wr_begin_q <= 1'b0;
      wr_end_q   <= 1'b0;
      int_ack_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      rd_begin_q <= 1'b0;
      rd_end_q   <= 1'b0;
      wr_begin_q <= 1'b0;
      wr_end_q   <= 1'b0;
      int_ack_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          // INTA wins; rd and wr together is illegal and simply waits.
          if (iorq_f && m1_f) begin
            state_q   <= StAck;
            busy_q    <= 1'b1;
            int_ack_q <= 1'b1;
            addr_q    <= bus.a;
          end else if (iorq_f && rd_f && !wr_f) begin
            state_q    <= StRd;
            busy_q     <= 1'b1;
            rd_begin_q <= 1'b1;
            addr_q     <= bus.a;
          end else if (iorq_f && wr_f && !rd_f) begin
            state_q    <= StWr;
            busy_q     <= 1'b1;
            wr_begin_q <= 1'b1;
            addr_q     <= bus.a;
            wdata_q    <= bus.d;
          end
        end
        StRd: begin
          if (!iorq_f || !rd_f) begin
            state_q  <= StGap;
            rd_end_q <= 1'b1;
          end
        end
        StWr: begin
          if (!iorq_f || !wr_f) begin
            state_q  <= StGap;
            wr_end_q <= 1'b1;
          end
        end
        StAck: begin
          if (!iorq_f) begin
            state_q <= StGap;
          end
        end
        StGap: begin
          // Hold off re-arming until the whole Z80 cycle has ended.
          if (!iorq_f && !rd_f && !wr_f) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.iorq        = iorq_q;
  assign bus.rd          = rd_q;
  assign bus.io_addr     = addr_q;
  assign bus.io_wdata    = wdata_q;
  assign bus.io_rd_begin = rd_begin_q;
  assign bus.io_rd_end   = rd_end_q;
  assign bus.io_wr_begin = wr_begin_q;
  assign bus.io_wr_end   = wr_end_q;
  assign bus.int_ack     = int_ack_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_zio_cycle.sv
// Scoreboard bench for zio_cycle: expected pulses are queued by the stimulus
// and matched by a negedge monitor; level outputs are checked directly.
module tb_zio_cycle;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned FILT        = 2;

  localparam logic [4:0] EvRb  = 5'b10000;
  localparam logic [4:0] EvRe  = 5'b01000;
  localparam logic [4:0] EvWb  = 5'b00100;
  localparam logic [4:0] EvWe  = 5'b00010;
  localparam logic [4:0] EvAck = 5'b00001;

  typedef struct packed {
    logic [4:0]  ev;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } exp_t;

  logic fclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 fclk = ~fclk;

  zio_cycle_if bus ();

  zio_cycle #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT       (FILT)
  ) dut (
    .fclk (fclk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_wdata = '0;

  task automatic cyc(input int n);
    repeat (n) @(posedge fclk);
    #1;
  endtask

  task automatic expect_ev(input logic [4:0] ev);
    exp_t e;
    e.ev    = ev;
    e.addr  = m_addr;
    e.wdata = m_wdata;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!bus.busy) break;
      cyc(1);
    end
    check("return_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.iorq_n = 1'b0;
    bus.rd_n   = 1'b0;
    bus.m1_n   = 1'b1;
    bus.wr_n   = 1'b1;
    bus.a      = 16'h1234;
    bus.d      = 8'h00;

    fork
      begin : monitor
        logic [4:0] ev;
        exp_t       e;
        forever begin
          @(negedge fclk);
          ev = {bus.io_rd_begin, bus.io_rd_end, bus.io_wr_begin, bus.io_wr_end, bus.int_ack};
          if (ev != 5'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_pulse: got %b want none", ev);
            end else begin
              e = exp_q.pop_front();
              if (ev !== e.ev || bus.io_addr !== e.addr || bus.io_wdata !== e.wdata) begin
                errors++;
                $display("FAIL pulse: got ev %b addr %h wdata %h want ev %b addr %h wdata %h",
                         ev, bus.io_addr, bus.io_wdata, e.ev, e.addr, e.wdata);
              end
            end
          end
        end
      end
    join_none

    // Reset held with a read already asserted on the bus.
    cyc(3);
    check("rst_iorq", 32'(bus.iorq), 32'd0);
    check("rst_rd", 32'(bus.rd), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_addr", 32'(bus.io_addr), 32'd0);
    check("rst_wdata", 32'(bus.io_wdata), 32'd0);
    m_addr = 16'h1234;
    expect_ev(EvRb);
    rst_n = 1'b1;
    cyc(3);
    check("lat_iorq_early", 32'(bus.iorq), 32'd0);
    cyc(1);
    check("lat_iorq", 32'(bus.iorq), 32'd1);
    check("lat_rd", 32'(bus.rd), 32'd1);
    check("lat_busy_early", 32'(bus.busy), 32'd0);
    cyc(1);
    check("lat_busy", 32'(bus.busy), 32'd1);
    expect_ev(EvRe);
    bus.iorq_n = 1'b1;
    bus.rd_n   = 1'b1;
    wait_idle();

    // Read; rd released first so GAP must hold busy until iorq goes too.
    bus.a  = 16'h00FE;
    m_addr = 16'h00FE;
    expect_ev(EvRb);
    expect_ev(EvRe);
    bus.iorq_n = 1'b0;
    bus.rd_n   = 1'b0;
    cyc(12);
    check("rd_busy", 32'(bus.busy), 32'd1);
    check("rd_addr", 32'(bus.io_addr), 32'h00FE);
    bus.rd_n = 1'b1;
    cyc(10);
    check("rd_gap_busy", 32'(bus.busy), 32'd1);
    check("rd_gap_rd", 32'(bus.rd), 32'd0);
    check("rd_gap_iorq", 32'(bus.iorq), 32'd1);
    bus.iorq_n = 1'b1;
    cyc(3);
    check("iorq_fall_early", 32'(bus.iorq), 32'd1);
    cyc(1);
    check("iorq_fall", 32'(bus.iorq), 32'd0);
    wait_idle();

    // Write; data changing mid-cycle must not disturb the latch.
    bus.a   = 16'h7FFD;
    bus.d   = 8'h17;
    m_addr  = 16'h7FFD;
    m_wdata = 8'h17;
    expect_ev(EvWb);
    expect_ev(EvWe);
    bus.iorq_n = 1'b0;
    bus.wr_n   = 1'b0;
    cyc(8);
    bus.d = 8'hFF;
    cyc(4);
    check("wr_wdata", 32'(bus.io_wdata), 32'h17);
    check("wr_addr", 32'(bus.io_addr), 32'h7FFD);
    check("wr_rd_level", 32'(bus.rd), 32'd0);
    bus.iorq_n = 1'b1;
    bus.wr_n   = 1'b1;
    wait_idle();
    check("wr_wdata_held", 32'(bus.io_wdata), 32'h17);

    // Interrupt acknowledge.
    bus.m1_n = 1'b0;
    cyc(6);
    check("m1_only_busy", 32'(bus.busy), 32'd0);
    bus.a  = 16'h00FF;
    m_addr = 16'h00FF;
    expect_ev(EvAck);
    bus.iorq_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("ack_iorq", 32'(bus.iorq), 32'd0);
    end
    check("ack_busy", 32'(bus.busy), 32'd1);
    bus.iorq_n = 1'b1;
    wait_idle();
    bus.m1_n = 1'b1;
    cyc(6);

    // One-clock iorq glitch under a held rd must be rejected.
    bus.rd_n = 1'b0;
    cyc(6);
    bus.iorq_n = 1'b0;
    cyc(1);
    bus.iorq_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("glitch_iorq", 32'(bus.iorq), 32'd0);
      check("glitch_busy", 32'(bus.busy), 32'd0);
    end
    bus.rd_n = 1'b1;
    cyc(6);

    // rd and wr both active: wait, then start a read once wr drops.
    bus.a = 16'h1F3B;
    bus.iorq_n = 1'b0;
    bus.rd_n   = 1'b0;
    bus.wr_n   = 1'b0;
    cyc(10);
    check("both_busy", 32'(bus.busy), 32'd0);
    check("both_iorq", 32'(bus.iorq), 32'd1);
    m_addr = 16'h1F3B;
    expect_ev(EvRb);
    expect_ev(EvRe);
    bus.wr_n = 1'b1;
    cyc(6);
    check("both_rd_busy", 32'(bus.busy), 32'd1);
    bus.iorq_n = 1'b1;
    bus.rd_n   = 1'b1;
    wait_idle();

    // Reset in the middle of a write aborts with no end pulse.
    bus.a   = 16'h1111;
    bus.d   = 8'hAA;
    m_addr  = 16'h1111;
    m_wdata = 8'hAA;
    expect_ev(EvWb);
    bus.iorq_n = 1'b0;
    bus.wr_n   = 1'b0;
    cyc(6);
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_addr", 32'(bus.io_addr), 32'd0);
    m_addr  = '0;
    m_wdata = '0;
    bus.iorq_n = 1'b1;
    bus.wr_n   = 1'b1;
    cyc(4);
    rst_n = 1'b1;
    cyc(10);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    bus.a  = 16'h0042;
    m_addr = 16'h0042;
    expect_ev(EvRb);
    expect_ev(EvRe);
    bus.iorq_n = 1'b0;
    bus.rd_n   = 1'b0;
    cyc(8);
    check("post_rst_rd_busy", 32'(bus.busy), 32'd1);
    check("post_rst_rd_addr", 32'(bus.io_addr), 32'h0042);
    bus.iorq_n = 1'b1;
    bus.rd_n   = 1'b1;
    wait_idle();

    cyc(5);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
